// File: rtl/compute_ctrl_pkg.sv
// Shared definitions for the compute-unit command sequencer: opcodes,
// FSM states and the per-element tag carried down the control delay line.
package compute_ctrl_pkg;

   localparam int unsigned OP_ARITH = 0;
   localparam int unsigned OP_CALC  = 1;
   localparam int unsigned OP_COMP  = 2;
   localparam int unsigned OP_CAST  = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } issue_state_e;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } ctrl_tag_t;

endpackage

// File: rtl/compute_issue_ctrl_if.sv
// Command handshake bundle between a command source (master) and the
// issue controller (slave).
interface compute_issue_ctrl_if #(
   parameter int OPCODE_BITS   = 4,
   parameter int FUNCTION_BITS = 4,
   parameter int ADDR_WIDTH    = 16,
   parameter int COUNT_WIDTH   = 16
);
   logic                     cmd_valid;
   logic                     cmd_ready;
   logic [OPCODE_BITS-1:0]   cmd_opcode;
   logic [FUNCTION_BITS-1:0] cmd_fn;
   logic [ADDR_WIDTH-1:0]    cmd_src0_base;
   logic [ADDR_WIDTH-1:0]    cmd_src1_base;
   logic [ADDR_WIDTH-1:0]    cmd_dst_base;
   logic [COUNT_WIDTH-1:0]   cmd_count;
   logic                     cmd_reduction;
   logic                     cmd_reduction_dim;

   modport master (
      output cmd_valid, cmd_opcode, cmd_fn, cmd_src0_base, cmd_src1_base,
             cmd_dst_base, cmd_count, cmd_reduction, cmd_reduction_dim,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_opcode, cmd_fn, cmd_src0_base, cmd_src1_base,
             cmd_dst_base, cmd_count, cmd_reduction, cmd_reduction_dim,
      output cmd_ready
   );
endinterface

// File: rtl/ctrl_delay_line.sv
// Shift pipe of {valid, first, last} tags following each issued read, with
// a tap where operands reach the compute unit and one where its result appears.
module ctrl_delay_line
   import compute_ctrl_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int TAP   = 1
) (
   input  logic      clk,
   input  logic      reset,
   input  ctrl_tag_t in_tag,
   output ctrl_tag_t tap_tag,
   output ctrl_tag_t out_tag,
   output logic      pending
);
   ctrl_tag_t pipe_q [1:DEPTH];
   ctrl_tag_t pipe_d [1:DEPTH];

   always_comb begin
      pipe_d[1] = in_tag;
      for (int s = 2; s <= DEPTH; s++) begin
         pipe_d[s] = pipe_q[s-1];
      end
   end

   always_ff @(posedge clk) begin
      for (int s = 1; s <= DEPTH; s++) begin
         if (reset) pipe_q[s] <= '0;
         else       pipe_q[s] <= pipe_d[s];
      end
   end

   // True while anything will still be in flight after this cycle's shift;
   // the final stage leaves the pipe at the coming edge.
   always_comb begin
      pending = 1'b0;
      for (int s = 1; s < DEPTH; s++) begin
         pending = pending | pipe_q[s].valid;
      end
   end

   assign tap_tag = pipe_q[TAP];
   assign out_tag = pipe_q[DEPTH];

endmodule

// File: rtl/compute_issue_ctrl.sv
// Command sequencer for one compute_unit lane: issues operand reads, aligns
// compute-unit controls with operand arrival and strobes result writes.
module compute_issue_ctrl
   import compute_ctrl_pkg::*;
#(
   parameter int OPCODE_BITS   = 4,
   parameter int FUNCTION_BITS = 4,
   parameter int ADDR_WIDTH    = 16,
   parameter int COUNT_WIDTH   = 16,
   parameter int RD_LATENCY    = 1,
   parameter int CU_LATENCY    = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   compute_issue_ctrl_if.slave      cmd,
   output logic                     rd_en,
   output logic [ADDR_WIDTH-1:0]    rd_addr0,
   output logic [ADDR_WIDTH-1:0]    rd_addr1,
   output logic [OPCODE_BITS-1:0]   cu_opcode,
   output logic [FUNCTION_BITS-1:0] cu_fn,
   output logic                     cu_acc_reset,
   output logic                     cu_reduction_flag,
   output logic                     cu_reduction_dim,
   output logic                     wr_en,
   output logic [ADDR_WIDTH-1:0]    wr_addr,
   output logic                     busy,
   output logic                     done
);
   localparam int DEPTH = RD_LATENCY + CU_LATENCY;

   issue_state_e             state_q, state_d;
   logic [OPCODE_BITS-1:0]   opcode_q, opcode_d;
   logic [FUNCTION_BITS-1:0] fn_q, fn_d;
   logic [ADDR_WIDTH-1:0]    dst_q, dst_d;
   logic [ADDR_WIDTH-1:0]    rd_addr0_q, rd_addr0_d;
   logic [ADDR_WIDTH-1:0]    rd_addr1_q, rd_addr1_d;
   logic [ADDR_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
   logic [COUNT_WIDTH-1:0]   count_q, count_d;
   logic [COUNT_WIDTH-1:0]   idx_q, idx_d;
   logic                     reduction_q, reduction_d;
   logic                     dim_q, dim_d;
   logic                     rd_en_q, rd_en_d;
   logic                     first_q, first_d;
   logic                     last_q, last_d;
   logic                     done_q, done_d;
   logic                     cmd_ready_w, cmd_hs, pending;
   ctrl_tag_t                tap_tag, out_tag;

   assign cmd_ready_w   = (state_q == ST_IDLE);
   assign cmd.cmd_ready = cmd_ready_w;
   assign cmd_hs        = cmd.cmd_valid & cmd_ready_w;

   ctrl_delay_line #(.DEPTH(DEPTH), .TAP(RD_LATENCY)) u_delay (
      .clk     (clk),
      .reset   (reset),
      .in_tag  ('{valid: rd_en_q, first: first_q, last: last_q}),
      .tap_tag (tap_tag),
      .out_tag (out_tag),
      .pending (pending)
   );

   // The last flag is computed one element ahead so the counter never needs
   // to reach N, which keeps the maximum count free of overflow.
   always_comb begin
      state_d     = state_q;
      opcode_d    = opcode_q;
      fn_d        = fn_q;
      dst_d       = dst_q;
      count_d     = count_q;
      reduction_d = reduction_q;
      dim_d       = dim_q;
      idx_d       = idx_q;
      rd_addr0_d  = rd_addr0_q;
      rd_addr1_d  = rd_addr1_q;
      rd_en_d     = 1'b0;
      first_d     = 1'b0;
      last_d      = 1'b0;
      done_d      = 1'b0;
      wr_cnt_d    = out_tag.valid ? wr_cnt_q + ADDR_WIDTH'(1) : wr_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_hs) begin
               opcode_d    = cmd.cmd_opcode;
               fn_d        = cmd.cmd_fn;
               dst_d       = cmd.cmd_dst_base;
               count_d     = cmd.cmd_count;
               reduction_d = cmd.cmd_reduction;
               dim_d       = cmd.cmd_reduction_dim;
               idx_d       = '0;
               wr_cnt_d    = '0;
               if (cmd.cmd_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d    = ST_ISSUE;
                  rd_en_d    = 1'b1;
                  first_d    = 1'b1;
                  last_d     = (cmd.cmd_count == COUNT_WIDTH'(1));
                  rd_addr0_d = cmd.cmd_src0_base;
                  rd_addr1_d = cmd.cmd_src1_base;
               end
            end
         end
         ST_ISSUE: begin
            if (last_q) begin
               state_d = ST_DRAIN;
            end else begin
               rd_en_d    = 1'b1;
               idx_d      = idx_q + COUNT_WIDTH'(1);
               last_d     = (idx_q + COUNT_WIDTH'(1)) == (count_q - COUNT_WIDTH'(1));
               rd_addr0_d = rd_addr0_q + ADDR_WIDTH'(1);
               rd_addr1_d = rd_addr1_q + ADDR_WIDTH'(1);
            end
         end
         ST_DRAIN: begin
            if (!pending) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         opcode_q    <= '0;
         fn_q        <= '0;
         dst_q       <= '0;
         count_q     <= '0;
         reduction_q <= 1'b0;
         dim_q       <= 1'b0;
         idx_q       <= '0;
         rd_addr0_q  <= '0;
         rd_addr1_q  <= '0;
         wr_cnt_q    <= '0;
         rd_en_q     <= 1'b0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         opcode_q    <= opcode_d;
         fn_q        <= fn_d;
         dst_q       <= dst_d;
         count_q     <= count_d;
         reduction_q <= reduction_d;
         dim_q       <= dim_d;
         idx_q       <= idx_d;
         rd_addr0_q  <= rd_addr0_d;
         rd_addr1_q  <= rd_addr1_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_en_q     <= rd_en_d;
         first_q     <= first_d;
         last_q      <= last_d;
         done_q      <= done_d;
      end
   end

   // A reduction folds every element into one result written to the base address.
   assign rd_en             = rd_en_q;
   assign rd_addr0          = rd_addr0_q;
   assign rd_addr1          = rd_addr1_q;
   assign cu_opcode         = opcode_q;
   assign cu_fn             = fn_q;
   assign cu_reduction_dim  = dim_q;
   assign cu_acc_reset      = tap_tag.valid & tap_tag.first;
   assign cu_reduction_flag = reduction_q & tap_tag.valid & ~tap_tag.first;
   assign wr_en             = out_tag.valid & (~reduction_q | out_tag.last);
   assign wr_addr           = reduction_q ? dst_q : dst_q + wr_cnt_q;
   assign busy              = (state_q != ST_IDLE);
   assign done              = done_q;

endmodule

// File: tb/tb_compute_issue_ctrl.sv
// Scoreboard bench for compute_issue_ctrl: one instance with default latencies
// and one with RD_LATENCY=2, CU_LATENCY=3.
module tb_compute_issue_ctrl;
   import compute_ctrl_pkg::*;

   typedef struct {
      int          cyc;
      logic [31:0] val;
   } exp_t;

   localparam int K_RD = 0, K_ACC = 1, K_FLAG = 2, K_WR = 3, K_DONE = 4;
   localparam int NO_CUT = 1 << 20;

   logic clk = 1'b0;
   logic reset_a, reset_b;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sbq [10][$];

   logic        rd_en_a, rd_en_b, wr_en_a, wr_en_b, busy_a, busy_b, done_a, done_b;
   logic        acc_a, acc_b, flag_a, flag_b, dim_a, dim_b;
   logic [15:0] a0_a, a0_b, a1_a, a1_b, wa_a, wa_b;
   logic [3:0]  op_a, op_b, fn_a, fn_b;

   compute_issue_ctrl_if if_a ();
   compute_issue_ctrl_if if_b ();

   compute_issue_ctrl dut_a (
      .clk(clk), .reset(reset_a), .cmd(if_a),
      .rd_en(rd_en_a), .rd_addr0(a0_a), .rd_addr1(a1_a),
      .cu_opcode(op_a), .cu_fn(fn_a), .cu_acc_reset(acc_a),
      .cu_reduction_flag(flag_a), .cu_reduction_dim(dim_a),
      .wr_en(wr_en_a), .wr_addr(wa_a), .busy(busy_a), .done(done_a)
   );

   compute_issue_ctrl #(.RD_LATENCY(2), .CU_LATENCY(3)) dut_b (
      .clk(clk), .reset(reset_b), .cmd(if_b),
      .rd_en(rd_en_b), .rd_addr0(a0_b), .rd_addr1(a1_b),
      .cu_opcode(op_b), .cu_fn(fn_b), .cu_acc_reset(acc_b),
      .cu_reduction_flag(flag_b), .cu_reduction_dim(dim_b),
      .wr_en(wr_en_b), .wr_addr(wa_b), .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int kind);
      case (kind)
         K_RD:    return "rd";
         K_ACC:   return "acc_reset";
         K_FLAG:  return "red_flag";
         K_WR:    return "wr";
         default: return "done";
      endcase
   endfunction

   function automatic void pushExp(input int d, input int kind, input int c,
                                   input logic [31:0] v, input int lim);
      exp_t e;
      if (c <= lim) begin
         e.cyc = c;
         e.val = v;
         sbq[d*5+kind].push_back(e);
      end
   endfunction

   function automatic bit queuesBusy(input int d);
      bit b = 1'b0;
      for (int j = 0; j < 5; j++) if (sbq[d*5+j].size() != 0) b = 1'b1;
      return b;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic compareEvent(input int d, input int kind, input logic [31:0] act);
      exp_t e;
      int   k = d*5 + kind;
      n_checks++;
      if (sbq[k].size() == 0) begin
         n_errors++;
         $display("[TB] FAIL %s dut%0d: unexpected event at cyc=%0d value=%h, required none",
                  kname(kind), d, cyc, act);
      end else begin
         e = sbq[k].pop_front();
         if (e.cyc != cyc || e.val !== act) begin
            n_errors++;
            $display("[TB] FAIL %s dut%0d: got cyc=%0d value=%h, required cyc=%0d value=%h",
                     kname(kind), d, cyc, act, e.cyc, e.val);
         end
      end
   endtask

   task automatic sampleDut(input int d, input logic rd, input logic [15:0] a0, a1,
                            input logic acc, flg, input logic [3:0] op, fn, input logic dim,
                            input logic wr, input logic [15:0] wa, input logic dn);
      if (rd)  compareEvent(d, K_RD, {a0, a1});
      if (acc) compareEvent(d, K_ACC, {23'd0, op, fn, dim});
      if (flg) compareEvent(d, K_FLAG, 32'd0);
      if (wr)  compareEvent(d, K_WR, {16'd0, wa});
      if (dn)  compareEvent(d, K_DONE, 32'd0);
   endtask

   // Monitor: every asserted DUT event is matched against the scoreboard.
   always @(negedge clk) begin
      sampleDut(0, rd_en_a, a0_a, a1_a, acc_a, flag_a, op_a, fn_a, dim_a, wr_en_a, wa_a, done_a);
      sampleDut(1, rd_en_b, a0_b, a1_b, acc_b, flag_b, op_b, fn_b, dim_b, wr_en_b, wa_b, done_b);
   end

   task automatic driveCmd(input int d, input logic v, input logic [3:0] op, fn,
                           input logic [15:0] s0, s1, dst, n, input logic red, dim);
      if (d == 0) begin
         if_a.cmd_valid = v; if_a.cmd_opcode = op; if_a.cmd_fn = fn;
         if_a.cmd_src0_base = s0; if_a.cmd_src1_base = s1; if_a.cmd_dst_base = dst;
         if_a.cmd_count = n; if_a.cmd_reduction = red; if_a.cmd_reduction_dim = dim;
      end else begin
         if_b.cmd_valid = v; if_b.cmd_opcode = op; if_b.cmd_fn = fn;
         if_b.cmd_src0_base = s0; if_b.cmd_src1_base = s1; if_b.cmd_dst_base = dst;
         if_b.cmd_count = n; if_b.cmd_reduction = red; if_b.cmd_reduction_dim = dim;
      end
   endtask

   // Presents a command at a negedge, records its acceptance cycle t and
   // pushes the expected event timeline (events after t+lim are not expected).
   task automatic applyStimulus(input int d, input logic [3:0] op, fn,
                                input logic [15:0] s0, s1, dst, n, input logic red, dim,
                                input int lim, output int t);
      int          waited = 0;
      int          dep    = (d == 0) ? 2 : 5;
      int          rl     = (d == 0) ? 1 : 2;
      logic [15:0] x0, x1, xw;
      driveCmd(d, 1'b1, op, fn, s0, s1, dst, n, red, dim);
      while (!((d == 0) ? if_a.cmd_ready : if_b.cmd_ready) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 100) begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL accept dut%0d: cmd_ready got 0 for 100 cycles, required 1", d);
         driveCmd(d, 1'b0, op, fn, s0, s1, dst, n, red, dim);
         t = -1000;
         return;
      end
      t = cyc;
      if (n == 16'd0) begin
         pushExp(d, K_DONE, t + 1, 32'd0, t + lim);
      end else begin
         for (int i = 0; i < int'(n); i++) begin
            x0 = s0 + 16'(i);
            x1 = s1 + 16'(i);
            xw = dst + 16'(i);
            pushExp(d, K_RD, t + 1 + i, {x0, x1}, t + lim);
            if (red && i > 0) pushExp(d, K_FLAG, t + 1 + i + rl, 32'd0, t + lim);
            if (!red) pushExp(d, K_WR, t + 1 + i + dep, {16'd0, xw}, t + lim);
         end
         pushExp(d, K_ACC, t + 1 + rl, {23'd0, op, fn, dim}, t + lim);
         if (red) pushExp(d, K_WR, t + int'(n) + dep, {16'd0, dst}, t + lim);
         pushExp(d, K_DONE, t + int'(n) + dep + 1, 32'd0, t + lim);
      end
      @(negedge clk);
      driveCmd(d, 1'b0, op, fn, s0, s1, dst, n, red, dim);
   endtask

   task automatic waitIdle(input int d);
      int k = 0;
      while (queuesBusy(d) && k < 300) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k >= 300) begin
         n_errors++;
         $display("[TB] FAIL drain dut%0d: expected events still pending after 300 cycles", d);
         for (int j = 0; j < 5; j++) sbq[d*5+j].delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic checkIdleOutputs(input string tag, input logic rdy, rd, acc, flg, dim,
                                   input logic wr, bsy, dn, input logic [15:0] a0, a1, wa,
                                   input logic [3:0] op, fn);
      checkOutput({tag, " cmd_ready"}, {31'd0, rdy}, 32'd1);
      checkOutput({tag, " strobes"}, {27'd0, rd, acc, flg, wr, dn}, 32'd0);
      checkOutput({tag, " busy/dim"}, {30'd0, bsy, dim}, 32'd0);
      checkOutput({tag, " rd_addrs"}, {a0, a1}, 32'd0);
      checkOutput({tag, " wr_addr/op/fn"}, {8'd0, wa, op, fn}, 32'd0);
   endtask

   initial begin
      int t, t2;
      reset_a = 1'b1;
      reset_b = 1'b1;
      driveCmd(0, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      driveCmd(1, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checkIdleOutputs("reset a", if_a.cmd_ready, rd_en_a, acc_a, flag_a, dim_a, wr_en_a,
                       busy_a, done_a, a0_a, a1_a, wa_a, op_a, fn_a);
      checkIdleOutputs("reset b", if_b.cmd_ready, rd_en_b, acc_b, flag_b, dim_b, wr_en_b,
                       busy_b, done_b, a0_b, a1_b, wa_b, op_b, fn_b);
      reset_a = 1'b0;
      reset_b = 1'b0;
      @(negedge clk);

      $display("[TB] plain command, N=4");
      applyStimulus(0, 4'(OP_ARITH), 4'h0, 16'h0010, 16'h0020, 16'h0030, 16'd4, 1'b0, 1'b0, NO_CUT, t);
      checkOutput("busy after accept", {31'd0, busy_a}, 32'd1);
      checkOutput("cmd_ready while busy", {31'd0, if_a.cmd_ready}, 32'd0);
      waitIdle(0);

      $display("[TB] reduction, N=4");
      applyStimulus(0, 4'(OP_CALC), 4'h3, 16'h0040, 16'h0050, 16'h0060, 16'd4, 1'b1, 1'b0, NO_CUT, t);
      waitIdle(0);

      $display("[TB] empty command");
      applyStimulus(0, 4'(OP_COMP), 4'h5, 16'h0001, 16'h0002, 16'h0003, 16'd0, 1'b0, 1'b0, NO_CUT, t);
      checkOutput("N=0 cmd_ready T+1", {31'd0, if_a.cmd_ready}, 32'd1);
      checkOutput("N=0 busy T+1", {31'd0, busy_a}, 32'd0);
      @(negedge clk);
      checkOutput("N=0 cmd_ready T+2", {31'd0, if_a.cmd_ready}, 32'd1);
      waitIdle(0);

      $display("[TB] address wrap, N=3");
      applyStimulus(0, 4'(OP_CAST), 4'hA, 16'hFFFE, 16'h8000, 16'hFFFF, 16'd3, 1'b0, 1'b0, NO_CUT, t);
      waitIdle(0);

      $display("[TB] single-element reduction");
      applyStimulus(0, 4'(OP_ARITH), 4'h2, 16'h0100, 16'h0200, 16'h0300, 16'd1, 1'b1, 1'b1, NO_CUT, t);
      waitIdle(0);

      $display("[TB] reset in the middle of N=8");
      applyStimulus(0, 4'(OP_CALC), 4'h1, 16'h0010, 16'h0020, 16'h0030, 16'd8, 1'b0, 1'b0, 3, t);
      repeat (2) @(negedge clk);
      reset_a = 1'b1;
      @(negedge clk);
      checkIdleOutputs("mid reset", if_a.cmd_ready, rd_en_a, acc_a, flag_a, dim_a, wr_en_a,
                       busy_a, done_a, a0_a, a1_a, wa_a, op_a, fn_a);
      reset_a = 1'b0;
      applyStimulus(0, 4'(OP_COMP), 4'h4, 16'h0070, 16'h0071, 16'h0072, 16'd2, 1'b0, 1'b0, NO_CUT, t2);
      checkOutput("accept right after reset", 32'(t2), 32'(t + 4));
      waitIdle(0);

      $display("[TB] long latencies, back-to-back commands");
      applyStimulus(1, 4'(OP_ARITH), 4'h1, 16'h0000, 16'h0008, 16'h0010, 16'd2, 1'b0, 1'b0, NO_CUT, t);
      applyStimulus(1, 4'(OP_CALC), 4'h6, 16'h0020, 16'h0028, 16'h0030, 16'd1, 1'b1, 1'b1, NO_CUT, t2);
      checkOutput("back-to-back accept cycle", 32'(t2), 32'(t + 8));
      waitIdle(1);
      waitIdle(0);

      for (int j = 0; j < 10; j++) begin
         checkOutput({"leftover ", kname(j % 5)}, 32'(sbq[j].size()), 32'd0);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
